alu_operand_stage: RTL

- Issue stage directly upstream of the ALU.
- Holds the 32x32 register file and decodes each issued operation into ALU operands (`sourceA`, `sourceB`) and the 3-bit ALU control code.
- Presents them through one registered valid/ready output slot.
- A pending-write scoreboard stalls issue on RAW/WAW hazards until the writeback port returns the result.

---
 rtl/cpu_defs.sv | 37 +++
 rtl/regfile_2r1w.sv | 52 +++++
 rtl/alu_operand_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, ALU control codes, slot states and
// the scoreboard busy test used by the issue stage.
package cpu_defs;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // A register is busy while pending, unless its result is arriving on
  // writeback this very cycle (the bypass supplies it); r0 is never busy.
  function automatic logic reg_busy(input logic [NREG-1:0] pend,
                                    input logic [AW-1:0]   r,
                                    input logic            wb_en,
                                    input logic [AW-1:0]   wb_addr);
    logic v_busy;
    if (r == {AW{1'b0}}) begin
      v_busy = 1'b0;
    end else begin
      v_busy = pend[r] && !(wb_en && (wb_addr == r));
    end
    return v_busy;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two asynchronous read ports with same-cycle write
// bypass, one synchronous write port, r0 hardwired to zero.
module regfile_2r1w
  import cpu_defs::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2
);

  logic [DW-1:0] r_mem [NREG];

  // Storage update; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
    end else if (i_we && (i_waddr != {AW{1'b0}})) begin
      r_mem[i_waddr] <= i_wdata;
    end else begin
      r_mem <= r_mem;
    end
  end

  // Read ports: r0 is zero, then bypass, then stored value.
  always_comb begin
    o_rdata1 = {DW{1'b0}};
    o_rdata2 = {DW{1'b0}};
    if (i_raddr1 == {AW{1'b0}}) begin
      o_rdata1 = {DW{1'b0}};
    end else if (i_we && (i_waddr == i_raddr1)) begin
      o_rdata1 = i_wdata;
    end else begin
      o_rdata1 = r_mem[i_raddr1];
    end
    if (i_raddr2 == {AW{1'b0}}) begin
      o_rdata2 = {DW{1'b0}};
    end else if (i_we && (i_waddr == i_raddr2)) begin
      o_rdata2 = i_wdata;
    end else begin
      o_rdata2 = r_mem[i_raddr2];
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU issue stage: register read, operand select, pending-write scoreboard
// and a single registered valid/ready output slot.
module alu_operand_stage
  import cpu_defs::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [2:0]    in_control,
  input  logic          in_wb_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sourceA,
  output logic [DW-1:0] out_sourceB,
  output logic [2:0]    out_control,
  output logic [AW-1:0] out_rd,
  output logic          out_wb_en,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  slot_state_e     r_state;
  logic [NREG-1:0] r_pend;
  logic [DW-1:0]   r_src_a;
  logic [DW-1:0]   r_src_b;
  logic [2:0]      r_control;
  logic [AW-1:0]   r_rd;
  logic            r_wb_en;

  logic [DW-1:0]   w_rd1;
  logic [DW-1:0]   w_rd2;
  logic            w_hazard;
  logic            w_ready;
  logic            w_accept;
  logic [NREG-1:0] w_pend_next;

  regfile_2r1w u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (wb_en),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (in_rs1),
    .i_raddr2 (in_rs2),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  // Hazard detection, handshake and next scoreboard (set beats clear).
  always_comb begin
    w_hazard = reg_busy(r_pend, in_rs1, wb_en, wb_addr)
            || (!in_use_imm && reg_busy(r_pend, in_rs2, wb_en, wb_addr))
            || (in_wb_en && reg_busy(r_pend, in_rd, wb_en, wb_addr));
    w_ready  = ((r_state == SLOT_EMPTY) || out_ready) && !w_hazard;
    w_accept = in_valid && w_ready;
    w_pend_next = r_pend;
    if (wb_en && (wb_addr != {AW{1'b0}})) begin
      w_pend_next[wb_addr] = 1'b0;
    end else begin
      w_pend_next = w_pend_next;
    end
    if (w_accept && in_wb_en && (in_rd != {AW{1'b0}})) begin
      w_pend_next[in_rd] = 1'b1;
    end else begin
      w_pend_next = w_pend_next;
    end
  end

  // Slot state machine with registered operand outputs and scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SLOT_EMPTY;
      r_pend    <= {NREG{1'b0}};
      r_src_a   <= {DW{1'b0}};
      r_src_b   <= {DW{1'b0}};
      r_control <= 3'b000;
      r_rd      <= {AW{1'b0}};
      r_wb_en   <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      if (w_accept) begin
        r_src_a   <= w_rd1;
        r_src_b   <= in_use_imm ? in_imm : w_rd2;
        r_control <= in_control;
        r_rd      <= in_rd;
        r_wb_en   <= in_wb_en;
      end
      case (r_state)
        SLOT_EMPTY: r_state <= w_accept ? SLOT_FULL : SLOT_EMPTY;
        SLOT_FULL:  r_state <= (out_ready && !w_accept) ? SLOT_EMPTY : SLOT_FULL;
        default:    r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign in_ready    = w_ready;
  assign out_valid   = (r_state == SLOT_FULL);
  assign out_sourceA = r_src_a;
  assign out_sourceB = r_src_b;
  assign out_control = r_control;
  assign out_rd      = r_rd;
  assign out_wb_en   = r_wb_en;

endmodule
